ahb_slave_mem: RTL and testbench

- AHB-Lite responder (slave) with a word-addressed memory behind it; the target end of the bus whose hsel lines come from the system address decoder.
- One instance per slave slot (hsel_1..hsel_4).
- Accepts single and burst transfers, inserts a configurable number of wait states, and returns two-cycle ERROR responses for illegal accesses.

---
 rtl/ahb_pkg.sv | 27 ++
 rtl/ahb_burst_addr_chk.sv | 51 +++++
 rtl/ahb_slave_mem.sv | 154 +++++++++++++++
 tb/tb_ahb_slave_mem.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the responder FSM state type.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_e;

endpackage

// File: rtl/ahb_burst_addr_chk.sv
// Expected-next-address tracker for SEQ beats; flags a SEQ whose address
// breaks the INCR/WRAP4 sequence or that has no NONSEQ before it.
module ahb_burst_addr_chk
  import ahb_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              hsel,
  input  logic              hready,
  input  logic [1:0]        htrans,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [2:0]        hburst,
  output logic              seq_err
);

  logic              valid_q;
  logic [ADDR_W-1:0] prev_q;
  logic [2:0]        burst_q;
  logic [ADDR_W-1:0] exp_addr;
  logic              active;

  assign active = hsel && hready;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      valid_q <= 1'b0;
      prev_q  <= '0;
      burst_q <= HBURST_SINGLE;
    end else if (active) begin
      if (htrans == HTRANS_IDLE) begin
        valid_q <= 1'b0;
      end else if (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ) begin
        prev_q  <= haddr;
        burst_q <= hburst;
        if (htrans == HTRANS_NONSEQ) valid_q <= 1'b1;
      end
    end
  end

  // WRAP4 only advances bits [3:2]; everything else is a plain +4 increment.
  always_comb begin
    exp_addr = prev_q + ADDR_W'(4);
    if (burst_q == HBURST_WRAP4)
      exp_addr = {prev_q[ADDR_W-1:4], prev_q[3:2] + 2'd1, 2'b00};
  end

  assign seq_err = (htrans == HTRANS_SEQ) && (!valid_q || haddr != exp_addr);

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite responder with a word memory, fixed wait states and two-cycle ERROR.
// Optional SEQ address checking is enabled with `define AHB_SLV_BURST_CHECK_EN.
//
// state   | meaning
// ST_IDLE | no data phase pending, ready for an address phase
// ST_WAIT | data phase stalled, counting down wait states
// ST_DATA | data phase completes this cycle (write lands on this edge)
// ST_ERR1 | first ERROR cycle, hreadyout low
// ST_ERR2 | second ERROR cycle, hreadyout high
module ahb_slave_mem
  import ahb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              hsel,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic [2:0]        hburst,
  input  logic              hready,
  input  logic [DATA_W-1:0] hwdata,
  output logic [DATA_W-1:0] hrdata,
  output logic              hreadyout,
  output logic              hresp
);

  localparam int IDX_W = $clog2(MEM_DEPTH);

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              wr_q, wr_d;
  logic [DATA_W-1:0] hrdata_q, hrdata_d;

  logic              accept;
  logic              illegal;
  logic              burst_err;
  logic              take_accept;
  logic              mem_we;
  logic [IDX_W-1:0]  addr_idx;

`ifdef AHB_SLV_BURST_CHECK_EN
  ahb_burst_addr_chk #(.ADDR_W(ADDR_W)) u_burst_chk (
    .hclk    (hclk),
    .hresetn (hresetn),
    .hsel    (hsel),
    .hready  (hready),
    .htrans  (htrans),
    .haddr   (haddr),
    .hburst  (hburst),
    .seq_err (burst_err)
  );
`else
  logic unused_hburst;
  assign unused_hburst = ^hburst;
  assign burst_err     = 1'b0;
`endif

  assign accept   = hsel && hready && (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ);
  assign addr_idx = haddr[IDX_W+1:2];
  assign illegal  = (hsize != HSIZE_WORD) || (haddr[1:0] != 2'b00) ||
                    (|haddr[ADDR_W-1:IDX_W+2]) || burst_err;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    wr_d        = wr_q;
    hrdata_d    = hrdata_q;
    mem_we      = 1'b0;
    take_accept = 1'b0;
    hreadyout   = 1'b1;
    hresp       = HRESP_OKAY;

    case (state_q)
      ST_IDLE: take_accept = 1'b1;
      ST_WAIT: begin
        hreadyout = 1'b0;
        if (cnt_q == 4'd1) begin
          state_d = ST_DATA;
          if (!wr_q) hrdata_d = mem[idx_q];
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DATA: begin
        mem_we      = wr_q;
        take_accept = 1'b1;
      end
      ST_ERR1: begin
        hreadyout = 1'b0;
        hresp     = HRESP_ERROR;
        state_d   = ST_ERR2;
      end
      ST_ERR2: begin
        hresp       = HRESP_ERROR;
        take_accept = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (take_accept) begin
      state_d = ST_IDLE;
      if (accept) begin
        if (illegal) begin
          state_d = ST_ERR1;
        end else begin
          idx_d = addr_idx;
          wr_d  = hwrite;
          if (WAIT_STATES == 0) begin
            state_d = ST_DATA;
            // The write completing on this edge has not reached mem yet.
            if (!hwrite)
              hrdata_d = (mem_we && idx_q == addr_idx) ? hwdata : mem[addr_idx];
          end else begin
            state_d = ST_WAIT;
            cnt_d   = 4'(WAIT_STATES);
          end
        end
      end
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      wr_q     <= 1'b0;
      hrdata_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      wr_q     <= wr_d;
      hrdata_q <= hrdata_d;
    end
  end

  always_ff @(posedge hclk) begin
    if (mem_we) mem[idx_q] <= hwdata;
  end

  assign hrdata = hrdata_q;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Directed bench: three responders (0, 1 and 3 wait states), each its own
// single-slave bus, driven from a per-cycle vector table.
module tb_ahb_slave_mem;
  import ahb_pkg::*;

  logic        hclk = 1'b0;
  logic        hresetn = 1'b0;
  logic [2:0]  sel = 3'b000;
  logic [31:0] haddr = '0;
  logic [1:0]  htrans = HTRANS_IDLE;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = HSIZE_WORD;
  logic [2:0]  hburst = HBURST_SINGLE;
  logic [31:0] hwdata = '0;

  logic [31:0] rd [3];
  logic        ro [3];
  logic        rs [3];

  always #5 hclk = ~hclk;

  ahb_slave_mem #(.WAIT_STATES(0)) u_d0 (
    .hclk(hclk), .hresetn(hresetn), .hsel(sel[0]), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hready(ro[0]), .hwdata(hwdata),
    .hrdata(rd[0]), .hreadyout(ro[0]), .hresp(rs[0]));

  ahb_slave_mem #(.WAIT_STATES(1)) u_d1 (
    .hclk(hclk), .hresetn(hresetn), .hsel(sel[1]), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hready(ro[1]), .hwdata(hwdata),
    .hrdata(rd[1]), .hreadyout(ro[1]), .hresp(rs[1]));

  ahb_slave_mem #(.WAIT_STATES(3)) u_d3 (
    .hclk(hclk), .hresetn(hresetn), .hsel(sel[2]), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hready(ro[2]), .hwdata(hwdata),
    .hrdata(rd[2]), .hreadyout(ro[2]), .hresp(rs[2]));

  // dut: 0/1/2 selects that responder; 3 selects none and observes responder 0
  typedef struct {
    int unsigned dut;
    logic [1:0]  trans;
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [31:0] wdata;
    logic        ero;
    logic        ers;
    logic        chk;
    logic [31:0] erd;
  } vec_t;

  vec_t vq[$];
  int   tests = 0;
  int   fails = 0;

  localparam logic [1:0] I = HTRANS_IDLE;
  localparam logic [1:0] N = HTRANS_NONSEQ;
  localparam logic [1:0] S = HTRANS_SEQ;
  localparam logic [2:0] W = HSIZE_WORD;

  function automatic vec_t mk(int unsigned d, logic [1:0] t, logic [31:0] a, logic w,
                              logic [2:0] sz, logic [2:0] b, logic [31:0] wd,
                              logic ero, logic ers, logic c, logic [31:0] erd);
    vec_t x;
    x.dut = d; x.trans = t; x.addr = a; x.wr = w; x.size = sz; x.burst = b;
    x.wdata = wd; x.ero = ero; x.ers = ers; x.chk = c; x.erd = erd;
    return x;
  endfunction

  function automatic void v(int unsigned d, logic [1:0] t, logic [31:0] a, logic w,
                            logic [2:0] sz, logic [2:0] b, logic [31:0] wd,
                            logic ero, logic ers, logic c, logic [31:0] erd);
    vq.push_back(mk(d, t, a, w, sz, b, wd, ero, ers, c, erd));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t x, input string tag);
    int unsigned d;
    @(negedge hclk);
    sel    = (x.dut < 3) ? (3'b001 << x.dut) : 3'b000;
    htrans = x.trans; haddr = x.addr; hwrite = x.wr;
    hsize  = x.size;  hburst = x.burst; hwdata = x.wdata;
    #1;
    d = (x.dut < 3) ? x.dut : 0;
    check({tag, " hreadyout"}, 32'(ro[d]), 32'(x.ero));
    check({tag, " hresp"},     32'(rs[d]), 32'(x.ers));
    if (x.chk) check({tag, " hrdata"}, rd[d], x.erd);
  endtask

  initial begin
    // reset state of every responder
    repeat (2) @(negedge hclk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset%0d hreadyout", i), 32'(ro[i]), 32'd1);
      check($sformatf("reset%0d hresp", i),     32'(rs[i]), 32'd0);
      check($sformatf("reset%0d hrdata", i),    rd[i],      32'd0);
    end
    hresetn = 1'b1;

    // 1 wait state: single write then read of 0x10
    v(1, N, 32'h10, 1, W, HBURST_SINGLE, 32'h0,        1, 0, 0, 0);
    v(1, N, 32'h10, 0, W, HBURST_SINGLE, 32'hDEADBEEF, 0, 0, 0, 0);
    v(1, N, 32'h10, 0, W, HBURST_SINGLE, 32'hDEADBEEF, 1, 0, 0, 0);
    v(1, I, 32'h0,  0, W, HBURST_SINGLE, 32'h0,        0, 0, 0, 0);
    v(1, I, 32'h0,  0, W, HBURST_SINGLE, 32'h0,        1, 0, 1, 32'hDEADBEEF);
    v(1, I, 32'h0,  0, W, HBURST_SINGLE, 32'h0,        1, 0, 0, 0);
    // 0 wait states: INCR4 write 1..4 then INCR4 read back
    v(0, N, 32'h00, 1, W, HBURST_INCR4, 32'd0, 1, 0, 0, 0);
    v(0, S, 32'h04, 1, W, HBURST_INCR4, 32'd1, 1, 0, 0, 0);
    v(0, S, 32'h08, 1, W, HBURST_INCR4, 32'd2, 1, 0, 0, 0);
    v(0, S, 32'h0C, 1, W, HBURST_INCR4, 32'd3, 1, 0, 0, 0);
    v(0, N, 32'h00, 0, W, HBURST_INCR4, 32'd4, 1, 0, 0, 0);
    v(0, S, 32'h04, 0, W, HBURST_INCR4, 32'd0, 1, 0, 1, 32'd1);
    v(0, S, 32'h08, 0, W, HBURST_INCR4, 32'd0, 1, 0, 1, 32'd2);
    v(0, S, 32'h0C, 0, W, HBURST_INCR4, 32'd0, 1, 0, 1, 32'd3);
    v(0, I, 32'h00, 0, W, HBURST_SINGLE, 32'd0, 1, 0, 1, 32'd4);
    // 0 wait states: read directly after write to the same word
    v(0, N, 32'h40, 1, W, HBURST_SINGLE, 32'h0,        1, 0, 0, 0);
    v(0, N, 32'h40, 0, W, HBURST_SINGLE, 32'hA5A55A5A, 1, 0, 0, 0);
    v(0, I, 32'h00, 0, W, HBURST_SINGLE, 32'h0,        1, 0, 1, 32'hA5A55A5A);
    // illegal size at 0x20 must leave mem[8] intact
    v(0, N, 32'h20, 1, W,      HBURST_SINGLE, 32'h0,   1, 0, 0, 0);
    v(0, N, 32'h20, 1, 3'b000, HBURST_SINGLE, 32'h88,  1, 0, 0, 0);
    v(0, I, 32'h00, 0, W,      HBURST_SINGLE, 32'hBAD, 0, 1, 0, 0);
    v(0, I, 32'h00, 0, W,      HBURST_SINGLE, 32'hBAD, 1, 1, 0, 0);
    v(0, N, 32'h20, 0, W,      HBURST_SINGLE, 32'h0,   1, 0, 0, 0);
    v(0, I, 32'h00, 0, W,      HBURST_SINGLE, 32'h0,   1, 0, 1, 32'h88);
    // out of range, then misaligned
    v(0, N, 32'h400, 0, W, HBURST_SINGLE, 32'h0, 1, 0, 0, 0);
    v(0, I, 32'h000, 0, W, HBURST_SINGLE, 32'h0, 0, 1, 0, 0);
    v(0, I, 32'h000, 0, W, HBURST_SINGLE, 32'h0, 1, 1, 0, 0);
    v(0, N, 32'h022, 0, W, HBURST_SINGLE, 32'h0, 1, 0, 0, 0);
    v(0, I, 32'h000, 0, W, HBURST_SINGLE, 32'h0, 0, 1, 0, 0);
    v(0, I, 32'h000, 0, W, HBURST_SINGLE, 32'h0, 1, 1, 0, 0);
    // hsel low: an illegal NONSEQ must be ignored
    v(3, N, 32'h400, 0, W, HBURST_SINGLE, 32'h0, 1, 0, 1, 32'h88);
    v(3, I, 32'h000, 0, W, HBURST_SINGLE, 32'h0, 1, 0, 1, 32'h88);
    // 3 wait states: write 0x30 = 0x1234 and read it back
    v(2, N, 32'h30, 1, W, HBURST_SINGLE, 32'h0,    1, 0, 0, 0);
    v(2, I, 32'h00, 0, W, HBURST_SINGLE, 32'h1234, 0, 0, 0, 0);
    v(2, I, 32'h00, 0, W, HBURST_SINGLE, 32'h1234, 0, 0, 0, 0);
    v(2, I, 32'h00, 0, W, HBURST_SINGLE, 32'h1234, 0, 0, 0, 0);
    v(2, I, 32'h00, 0, W, HBURST_SINGLE, 32'h1234, 1, 0, 0, 0);
    v(2, N, 32'h30, 0, W, HBURST_SINGLE, 32'h0,    1, 0, 0, 0);
    v(2, I, 32'h00, 0, W, HBURST_SINGLE, 32'h0,    0, 0, 0, 0);
    v(2, I, 32'h00, 0, W, HBURST_SINGLE, 32'h0,    0, 0, 0, 0);
    v(2, I, 32'h00, 0, W, HBURST_SINGLE, 32'h0,    0, 0, 0, 0);
    v(2, I, 32'h00, 0, W, HBURST_SINGLE, 32'h0,    1, 0, 1, 32'h1234);

    for (int i = 0; i < vq.size(); i++) apply(vq[i], $sformatf("vec%0d", i));

    // reset asserted in the second wait cycle of a write to 0x30
    apply(mk(2, N, 32'h30, 1, W, HBURST_SINGLE, 32'h0,       1, 0, 0, 0), "rstw a");
    apply(mk(2, I, 32'h00, 0, W, HBURST_SINGLE, 32'hFFFF0000, 0, 0, 0, 0), "rstw b");
    @(negedge hclk);
    #2 hresetn = 1'b0;
    #1;
    check("rstw hreadyout", 32'(ro[2]), 32'd1);
    check("rstw hresp",     32'(rs[2]), 32'd0);
    check("rstw hrdata",    rd[2],      32'd0);
    @(negedge hclk);
    hresetn = 1'b1;
    apply(mk(2, N, 32'h30, 0, W, HBURST_SINGLE, 32'h0, 1, 0, 0, 0), "rstr a");
    for (int i = 0; i < 3; i++)
      apply(mk(2, I, 32'h0, 0, W, HBURST_SINGLE, 32'h0, 0, 0, 0, 0), $sformatf("rstr w%0d", i));
    apply(mk(2, I, 32'h00, 0, W, HBURST_SINGLE, 32'h0, 1, 0, 1, 32'h1234), "rstr data");

`ifdef AHB_SLV_BURST_CHECK_EN
    // WRAP4 from 0x38 wraps inside its 16-byte block; a repeated address errors
    apply(mk(0, N, 32'h38, 0, W, HBURST_WRAP4, 32'h0, 1, 0, 0, 0), "wrap 38");
    apply(mk(0, S, 32'h3C, 0, W, HBURST_WRAP4, 32'h0, 1, 0, 0, 0), "wrap 3c");
    apply(mk(0, S, 32'h30, 0, W, HBURST_WRAP4, 32'h0, 1, 0, 0, 0), "wrap 30");
    apply(mk(0, S, 32'h34, 0, W, HBURST_WRAP4, 32'h0, 1, 0, 0, 0), "wrap 34");
    apply(mk(0, I, 32'h00, 0, W, HBURST_WRAP4, 32'h0, 1, 0, 0, 0), "wrap end");
    apply(mk(0, N, 32'h38, 0, W, HBURST_WRAP4, 32'h0, 1, 0, 0, 0), "bad 38");
    apply(mk(0, S, 32'h38, 0, W, HBURST_WRAP4, 32'h0, 1, 0, 0, 0), "bad seq");
    apply(mk(0, I, 32'h00, 0, W, HBURST_WRAP4, 32'h0, 0, 1, 0, 0), "bad err1");
    apply(mk(0, I, 32'h00, 0, W, HBURST_WRAP4, 32'h0, 1, 1, 0, 0), "bad err2");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
